// File: rtl/core_bus_pkg.sv
// Shared bus constants for core_top peripherals: the LED/GPIO register map
// offsets and the default LED base address used by core_top's address decoder.
package core_bus_pkg;

    // Default base of the 32-byte LED/GPIO window.
    localparam logic [31:0] LED_BASE_ADDR = 32'h8000_0000;

    // Byte offsets inside the LED/GPIO window (word aligned).
    localparam logic [4:0] OFS_OUT       = 5'h00;
    localparam logic [4:0] OFS_SET       = 5'h04;
    localparam logic [4:0] OFS_CLR       = 5'h08;
    localparam logic [4:0] OFS_TGL       = 5'h0C;
    localparam logic [4:0] OFS_IN        = 5'h10;
    localparam logic [4:0] OFS_BLINK_EN  = 5'h14;
    localparam logic [4:0] OFS_BLINK_DIV = 5'h18;

    // The window has eight word slots but only the first seven are mapped;
    // slot 7 (offset 0x1C) is left for whatever sits behind the LED block.
    function automatic logic slot_is_mapped(input logic [2:0] word_idx);
        return word_idx != 3'd7;
    endfunction

endpackage

// File: rtl/mmio_led_gpio_if.sv
// Core data-bus port as seen by the LED/GPIO peripheral.
// Handshake: a write occurs on every clk edge where wr_en is high and hit is
// high; a read is a combinational lookup, rd_data is valid in the same cycle
// as rd_en & hit and is zero otherwise. There is no wait state or ready.
interface mmio_led_gpio_if;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        hit;

    // Core side drives the address/strobes and receives the read data.
    modport master (
        output addr, wr_data, wr_en, rd_en,
        input  rd_data, hit
    );

    // Peripheral side decodes the address and returns data plus hit.
    modport slave (
        input  addr, wr_data, wr_en, rd_en,
        output rd_data, hit
    );
endinterface

// File: rtl/mmio_led_gpio_sync.sv
// Multi-flop synchroniser for the asynchronous gpio_in pins. A pin change
// appears at q_o exactly STAGES clock edges after it is first sampled.
module gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the pin values down the chain; reset clears every stage at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/mmio_led_gpio.sv
// Memory-mapped LED/GPIO peripheral: output register with atomic set/clear/
// toggle, synchronised input readback and per-channel hardware blink.
module mmio_led_gpio
    import core_bus_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR   = LED_BASE_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mmio_led_gpio_if.slave   bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] leds
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic             in_window;
    logic             hit_w;
    logic [4:0]       ofs;
    logic             wr_fire;
    logic [WIDTH-1:0] wr_w;
    logic             unused_addr_lsbs;

    assign in_window = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign hit_w     = in_window && slot_is_mapped(bus.addr[4:2]);
    // Byte lanes are ignored: every access is a full word.
    assign ofs       = {bus.addr[4:2], 2'b00};
    assign wr_fire   = bus.wr_en && hit_w;
    assign wr_w      = bus.wr_data[WIDTH-1:0];
    assign unused_addr_lsbs = ^bus.addr[1:0];

    assign bus.hit = hit_w;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] en_q,  en_d;
    logic [31:0]      div_q, div_d;
    logic             div_wr;
    logic [31:0]      cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic [WIDTH-1:0] in_w;

    // Input synchroniser; IN reads the last stage.
    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gpio_in),
        .q_o   (in_w)
    );

    // Register-file next state from the (at most one) write this cycle.
    always_comb begin
        out_d  = out_q;
        en_d   = en_q;
        div_d  = div_q;
        div_wr = 1'b0;
        if (wr_fire) begin
            case (ofs)
                OFS_OUT:       out_d = wr_w;
                OFS_SET:       out_d = out_q | wr_w;
                OFS_CLR:       out_d = out_q & ~wr_w;
                OFS_TGL:       out_d = out_q ^ wr_w;
                OFS_BLINK_EN:  en_d  = wr_w;
                OFS_BLINK_DIV: begin
                    div_d  = bus.wr_data;
                    div_wr = 1'b1;
                end
                default:       ;
            endcase
        end
    end

    // Blink divider: a BLINK_DIV write restarts the period from phase 0 and
    // wins over a terminal-count toggle landing on the same edge.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (div_wr || (div_q == 32'd0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == div_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 32'd1;
        end
    end

    // LED drive uses next-state values so a write shows on the same edge.
    always_comb begin
        leds_d = out_d ^ (en_d & {WIDTH{phase_d}});
    end

    // All peripheral state; async reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            en_q    <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            leds_q  <= '0;
        end else begin
            out_q   <= out_d;
            en_q    <= en_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            leds_q  <= leds_d;
        end
    end

    assign leds = leds_q;

    // ------------------------------------------------------------------
    // Read path (combinational, no side effects, zero-extended)
    // ------------------------------------------------------------------
    // Select the addressed register; write-only and unmapped slots read 0.
    always_comb begin
        bus.rd_data = '0;
        if (bus.rd_en && hit_w) begin
            case (ofs)
                OFS_OUT:       bus.rd_data[WIDTH-1:0] = out_q;
                OFS_IN:        bus.rd_data[WIDTH-1:0] = in_w;
                OFS_BLINK_EN:  bus.rd_data[WIDTH-1:0] = en_q;
                OFS_BLINK_DIV: bus.rd_data            = div_q;
                default:       bus.rd_data            = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_led_gpio.sv
// Bench for mmio_led_gpio: directed steps followed by random traffic, all
// checked against a behavioural model of the register map and blink timing.
module tb_mmio_led_gpio;

    localparam int unsigned W    = 8;
    localparam int unsigned SS   = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] gpio_in;
    logic [W-1:0] leds;

    mmio_led_gpio_if bus ();

    mmio_led_gpio #(
        .WIDTH       (W),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (SS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .gpio_in (gpio_in),
        .leds    (leds)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0]    m_out;
    logic [W-1:0]    m_en;
    logic [31:0]     m_div;
    longint unsigned m_t;        // edges since the current blink period began
    logic [W-1:0]    m_gpio_hist[$];
    logic [W-1:0]    m_leds;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        logic [31:0] rel;
        rel = (a & ~32'h3) - BASE;
        return rel <= 32'h18;
    endfunction

    function automatic logic m_phase();
        longint unsigned period;
        if (m_div == 32'd0) return 1'b0;
        period = {32'd0, m_div} + 64'd1;
        return ((m_t / period) % 2) == 64'd1;
    endfunction

    function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (rd && m_hit(a)) begin
            case (a[4:0] & 5'h1C)
                5'h00:   r = {24'd0, m_out};
                5'h10:   r = {24'd0, m_gpio_hist[0]};
                5'h14:   r = {24'd0, m_en};
                5'h18:   r = m_div;
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_out  = '0;
        m_en   = '0;
        m_div  = '0;
        m_t    = 0;
        m_leds = '0;
        m_gpio_hist = {};
        repeat (SS) m_gpio_hist.push_back('0);
    endtask

    // Advance the model by one clock edge using the inputs presented at it.
    task automatic model_edge();
        logic div_written;
        div_written = 1'b0;
        if (bus.wr_en && m_hit(bus.addr)) begin
            case (bus.addr[4:0] & 5'h1C)
                5'h00: m_out = bus.wr_data[W-1:0];
                5'h04: m_out = m_out | bus.wr_data[W-1:0];
                5'h08: m_out = m_out & ~bus.wr_data[W-1:0];
                5'h0C: m_out = m_out ^ bus.wr_data[W-1:0];
                5'h14: m_en  = bus.wr_data[W-1:0];
                5'h18: begin
                    m_div = bus.wr_data;
                    div_written = 1'b1;
                end
                default: ;
            endcase
        end
        if (div_written || m_div == 32'd0) m_t = 0;
        else m_t++;
        m_gpio_hist.push_back(gpio_in);
        if (m_gpio_hist.size() > SS) void'(m_gpio_hist.pop_front());
        m_leds = m_out ^ (m_en & {W{m_phase()}});
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, then
    // check the registered LED outputs just after the edge.
    task automatic cycle(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        #1;
        check("hit", {31'd0, bus.hit}, {31'd0, m_hit(a)});
        check("rd_data", bus.rd_data, m_read(rd, a));
        @(posedge clk);
        model_edge();
        #1;
        check("leds", {24'd0, leds}, {24'd0, m_leds});
    endtask

    task automatic wr(input logic [4:0] ofs, input logic [31:0] d);
        cycle(1'b1, 1'b0, BASE + {27'd0, ofs}, d);
    endtask

    task automatic rd(input logic [4:0] ofs);
        cycle(1'b0, 1'b1, BASE + {27'd0, ofs}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Assert reset a little after an edge, check leds cleared before the
    // next edge, hold for two edges, release on a falling edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("leds_async_reset", {24'd0, leds}, 32'd0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("leds_in_reset", {24'd0, leds}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat_got;
        logic [7:0] pat_exp;
        logic [4:0] rofs;
        logic [31:0] ra;
        logic [31:0] rdat;

        rst_n       = 1'b0;
        gpio_in     = '0;
        bus.addr    = '0;
        bus.wr_data = '0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        model_reset();
        #1;
        check("leds_por", {24'd0, leds}, 32'd0);
        bus.addr  = BASE;
        bus.rd_en = 1'b1;
        #1;
        check("rd_out_in_reset", bus.rd_data, 32'd0);
        bus.rd_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain OUT write and readback
        wr(5'h00, 32'h0000_00A5);
        check("leds_A5", {24'd0, leds}, 32'h0000_00A5);
        rd(5'h00);

        // Atomic set/clear/toggle
        wr(5'h00, 32'h0000_00F0);
        wr(5'h04, 32'h0000_000F);
        check("leds_set", {24'd0, leds}, 32'h0000_00FF);
        wr(5'h08, 32'h0000_0081);
        check("leds_clr", {24'd0, leds}, 32'h0000_007E);
        wr(5'h0C, 32'h0000_00FF);
        check("leds_tgl", {24'd0, leds}, 32'h0000_0081);
        rd(5'h04);
        rd(5'h08);
        rd(5'h0C);
        // Bits above WIDTH are dropped
        wr(5'h00, 32'hFFFF_FF00);
        rd(5'h00);

        // Blink with period 4 on channel 0
        wr(5'h00, 32'h0);
        wr(5'h14, 32'h1);
        wr(5'h18, 32'd3);
        pat_got[0] = leds[0];
        for (int i = 1; i < 8; i++) begin
            idle(1);
            pat_got[i] = leds[0];
        end
        pat_exp = 8'hF0;
        check("blink_pattern", {24'd0, pat_got}, {24'd0, pat_exp});
        rd(5'h14);
        rd(5'h18);

        // Mid-blink period change, then blink off
        idle(1);
        wr(5'h18, 32'd1);
        check("div_rewrite_phase0", {31'd0, leds[0]}, 32'd0);
        idle(6);
        wr(5'h00, 32'h0000_0055);
        wr(5'h14, 32'h0000_00FF);
        idle(5);
        wr(5'h18, 32'd0);
        idle(3);
        check("blink_off_steady", {24'd0, leds}, 32'h0000_0055);

        // Synchronised input
        gpio_in = 8'h3C;
        rd(5'h10);
        rd(5'h10);
        check("in_after_2_edges", bus.rd_data, 32'h0000_003C);
        rd(5'h10);

        // Unmapped slot and out-of-window accesses
        cycle(1'b0, 1'b1, 32'h8000_001C, 32'd0);
        check("unmapped_hit", {31'd0, bus.hit}, 32'd0);
        cycle(1'b1, 1'b1, 32'h8000_001C, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 32'h8000_0003, 32'd0);

        // Async reset with all LEDs lit, then registers read zero
        wr(5'h00, 32'h0000_00FF);
        check("leds_FF", {24'd0, leds}, 32'h0000_00FF);
        async_reset();
        for (int i = 0; i < 7; i++) rd(5'(i * 4));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            rofs = 5'($urandom_range(0, 7) * 4);
            ra   = BASE + {27'd0, rofs} + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            rdat = $urandom;
            if (rofs == 5'h18) rdat = 32'($urandom_range(0, 5));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rdat);
            if (n == 200) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
